// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage SRAM access controller.
package mem_pkg;

  localparam int unsigned SRAM_AW         = 18;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned BASE_ADDR_DEF   = 1024;

  // Word index width: one SRAM address bit selects the half-word.
  localparam int unsigned IDX_W = SRAM_AW - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times the wait states of one SRAM half-word phase.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CW          = $clog2(WAIT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load has priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: splits a 32-bit load/store into two 16-bit SRAM
// phases with fixed wait states and freezes the pipeline until it is done.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_R_EN,
  input  logic                 MEM_W_EN,
  input  logic [31:0]          ALU_result,
  input  logic [31:0]          Val_Rm,
  output logic [31:0]          mem_rdata,
  output logic                 ready,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic [SRAM_DW-1:0]   SRAM_DQ_out,
  input  logic [SRAM_DW-1:0]   SRAM_DQ_in,
  output logic                 SRAM_DQ_oe,
  output logic                 SRAM_WE_N
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic [SRAM_DW-1:0] lo_q, lo_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               req;
  logic               cnt_load;
  logic               cnt_zero;
  logic [31:0]        offset;
  logic [IDX_W-1:0]   addr_idx;
  logic               unused_offset_bits;

  // Word index relative to the SRAM window; wraps modulo the SRAM size.
  assign req                = MEM_R_EN | MEM_W_EN;
  assign offset             = ALU_result - 32'(BASE_ADDR);
  assign addr_idx           = offset[IDX_W+1:2];
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .CW          (CW)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .value (CNT_RELOAD),
    .zero  (cnt_zero)
  );

  // Next-state logic: latch the request in IDLE, sequence LO -> HI -> DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d    = addr_idx;
          wdata_d  = Val_Rm;
          wr_d     = MEM_W_EN;
          cnt_load = 1'b1;
          state_d  = LO;
        end
      end
      LO: begin
        if (cnt_zero) begin
          if (!wr_q) begin
            lo_d = SRAM_DQ_in;
          end
          cnt_load = 1'b1;
          state_d  = HI;
        end
      end
      HI: begin
        if (cnt_zero) begin
          if (!wr_q) begin
            rdata_d = {SRAM_DQ_in, lo_q};
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  // Moore SRAM strobes decoded from state and latched direction; ready handshake.
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_WE_N   = 1'b1;
    SRAM_DQ_oe  = 1'b0;
    ready       = 1'b0;

    case (state_q)
      LO: begin
        SRAM_ADDR = {idx_q, 1'b0};
        if (wr_q) begin
          SRAM_DQ_out = wdata_q[15:0];
          SRAM_WE_N   = 1'b0;
          SRAM_DQ_oe  = 1'b1;
        end
      end
      HI: begin
        SRAM_ADDR = {idx_q, 1'b1};
        if (wr_q) begin
          SRAM_DQ_out = wdata_q[31:16];
          SRAM_WE_N   = 1'b0;
          SRAM_DQ_oe  = 1'b1;
        end
      end
      IDLE: begin
        ready = ~req;
      end
      DONE: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase

    // While reset is held the controller is logically idle.
    if (rst) begin
      ready = ~req;
    end
  end

  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 16-bit SRAM.
module tb_mem_access_ctrl;

  localparam int unsigned W  = 2;
  localparam int unsigned BA = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_result, Val_Rm;
  logic [31:0] mem_rdata;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic [15:0] SRAM_DQ_in = 16'h0000;
  logic        SRAM_DQ_oe;
  logic        SRAM_WE_N;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BA)) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .ALU_result  (ALU_result),
    .Val_Rm      (Val_Rm),
    .mem_rdata   (mem_rdata),
    .ready       (ready),
    .SRAM_ADDR   (SRAM_ADDR),
    .SRAM_DQ_out (SRAM_DQ_out),
    .SRAM_DQ_in  (SRAM_DQ_in),
    .SRAM_DQ_oe  (SRAM_DQ_oe),
    .SRAM_WE_N   (SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: write on the rising edge, read data presented mid-cycle.
  logic [15:0] sram [int];
  always @(posedge clk) begin
    if (!SRAM_WE_N && SRAM_DQ_oe) sram[int'(SRAM_ADDR)] = SRAM_DQ_out;
  end
  always @(negedge clk) begin
    SRAM_DQ_in = sram.exists(int'(SRAM_ADDR)) ? sram[int'(SRAM_ADDR)] : 16'h0000;
  end

  function automatic logic [15:0] sram_peek(int a);
    return sram.exists(a) ? sram[a] : 16'h0000;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r, w;
    logic [31:0] alu, val;
    logic        rdy, we_n, oe;
    logic [17:0] addr;
    logic [15:0] dq;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t v(logic r, logic w, logic [31:0] alu, logic [31:0] val,
                             logic rdy, logic we_n, logic oe, logic [17:0] addr,
                             logic [15:0] dq, logic [31:0] rdata);
    vec_t t;
    t.r = r; t.w = w; t.alu = alu; t.val = val;
    t.rdy = rdy; t.we_n = we_n; t.oe = oe; t.addr = addr; t.dq = dq; t.rdata = rdata;
    return t;
  endfunction

  task automatic drive(logic r, logic w, logic [31:0] alu, logic [31:0] val);
    MEM_R_EN = r; MEM_W_EN = w; ALU_result = alu; Val_Rm = val;
  endtask

  // One row per clock cycle: drive just after the edge, check mid-cycle.
  task automatic run_rows(string tag, vec_t rows[$]);
    foreach (rows[i]) begin
      @(posedge clk); #1;
      drive(rows[i].r, rows[i].w, rows[i].alu, rows[i].val);
      @(negedge clk);
      check($sformatf("%s[%0d].ready", tag, i), 32'(ready), 32'(rows[i].rdy));
      check($sformatf("%s[%0d].we_n", tag, i), 32'(SRAM_WE_N), 32'(rows[i].we_n));
      check($sformatf("%s[%0d].oe", tag, i), 32'(SRAM_DQ_oe), 32'(rows[i].oe));
      check($sformatf("%s[%0d].addr", tag, i), 32'(SRAM_ADDR), 32'(rows[i].addr));
      // Read-phase DQ_out is a don't-care; check it when writing or fully idle.
      if (!rows[i].we_n || rows[i].addr == 18'h0)
        check($sformatf("%s[%0d].dq", tag, i), 32'(SRAM_DQ_out), 32'(rows[i].dq));
      check($sformatf("%s[%0d].rdata", tag, i), mem_rdata, rows[i].rdata);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    vec_t post[$];
    localparam logic [31:0] D1 = 32'hDEADBEEF;
    localparam logic [31:0] D2 = 32'hCAFEF00D;
    localparam logic [31:0] P  = 32'h56781234;
    localparam logic [31:0] D3 = 32'hA5A55A5A;

    sram[6] = 16'h1234;
    sram[7] = 16'h5678;

    // Store 1032 (idx 2 -> addr 4/5), frozen request held through DONE.
    tbl.push_back(v(0,1,1032,D1, 0,1,0,18'h0,    16'h0,   32'h0));
    tbl.push_back(v(0,1,1032,D1, 0,0,1,18'h4,    16'hBEEF,32'h0));
    tbl.push_back(v(0,1,1032,D1, 0,0,1,18'h4,    16'hBEEF,32'h0));
    tbl.push_back(v(0,1,1032,D1, 0,0,1,18'h5,    16'hDEAD,32'h0));
    tbl.push_back(v(0,1,1032,D1, 0,0,1,18'h5,    16'hDEAD,32'h0));
    tbl.push_back(v(0,1,1032,D1, 1,1,0,18'h0,    16'h0,   32'h0));
    tbl.push_back(v(0,0,0,0,     1,1,0,18'h0,    16'h0,   32'h0));
    // Load 1032, held through DONE, then back-to-back load of 1036 (addr 6/7).
    tbl.push_back(v(1,0,1032,0,  0,1,0,18'h0,    16'h0,   32'h0));
    tbl.push_back(v(1,0,1032,0,  0,1,0,18'h4,    16'h0,   32'h0));
    tbl.push_back(v(1,0,1032,0,  0,1,0,18'h4,    16'h0,   32'h0));
    tbl.push_back(v(1,0,1032,0,  0,1,0,18'h5,    16'h0,   32'h0));
    tbl.push_back(v(1,0,1032,0,  0,1,0,18'h5,    16'h0,   32'h0));
    tbl.push_back(v(1,0,1032,0,  1,1,0,18'h0,    16'h0,   D1));
    tbl.push_back(v(1,0,1036,0,  0,1,0,18'h0,    16'h0,   D1));
    tbl.push_back(v(1,0,1036,0,  0,1,0,18'h6,    16'h0,   D1));
    tbl.push_back(v(1,0,1036,0,  0,1,0,18'h6,    16'h0,   D1));
    tbl.push_back(v(1,0,1036,0,  0,1,0,18'h7,    16'h0,   D1));
    tbl.push_back(v(1,0,1036,0,  0,1,0,18'h7,    16'h0,   D1));
    tbl.push_back(v(1,0,1036,0,  1,1,0,18'h0,    16'h0,   P));
    tbl.push_back(v(0,0,0,0,     1,1,0,18'h0,    16'h0,   P));
    // Both enables set at 1020: write wins, index wraps to 0x1FFFF.
    tbl.push_back(v(1,1,1020,D2, 0,1,0,18'h0,    16'h0,   P));
    tbl.push_back(v(1,1,1020,D2, 0,0,1,18'h3FFFE,16'hF00D,P));
    tbl.push_back(v(1,1,1020,D2, 0,0,1,18'h3FFFE,16'hF00D,P));
    tbl.push_back(v(1,1,1020,D2, 0,0,1,18'h3FFFF,16'hCAFE,P));
    tbl.push_back(v(1,1,1020,D2, 0,0,1,18'h3FFFF,16'hCAFE,P));
    tbl.push_back(v(1,1,1020,D2, 1,1,0,18'h0,    16'h0,   P));
    tbl.push_back(v(0,0,0,0,     1,1,0,18'h0,    16'h0,   P));

    // Store 1044 (idx 5 -> addr 10/11) after a mid-access reset.
    post.push_back(v(0,1,1044,D3, 0,1,0,18'h0, 16'h0,   32'h0));
    post.push_back(v(0,1,1044,D3, 0,0,1,18'hA, 16'h5A5A,32'h0));
    post.push_back(v(0,1,1044,D3, 0,0,1,18'hA, 16'h5A5A,32'h0));
    post.push_back(v(0,1,1044,D3, 0,0,1,18'hB, 16'hA5A5,32'h0));
    post.push_back(v(0,1,1044,D3, 0,0,1,18'hB, 16'hA5A5,32'h0));
    post.push_back(v(0,1,1044,D3, 1,1,0,18'h0, 16'h0,   32'h0));
    post.push_back(v(0,0,0,0,     1,1,0,18'h0, 16'h0,   32'h0));

    // Reset behaviour, including ready = ~request while reset is held.
    rst = 1'b1;
    drive(0, 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.ready_noreq", 32'(ready), 32'h1);
    check("rst.we_n", 32'(SRAM_WE_N), 32'h1);
    check("rst.oe", 32'(SRAM_DQ_oe), 32'h0);
    check("rst.rdata", mem_rdata, 32'h0);
    MEM_R_EN = 1'b1;
    #1;
    check("rst.ready_req", 32'(ready), 32'h0);
    MEM_R_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("idle[%0d].ready", c), 32'(ready), 32'h1);
      check($sformatf("idle[%0d].we_n", c), 32'(SRAM_WE_N), 32'h1);
      check($sformatf("idle[%0d].oe", c), 32'(SRAM_DQ_oe), 32'h0);
      check($sformatf("idle[%0d].addr", c), 32'(SRAM_ADDR), 32'h0);
      check($sformatf("idle[%0d].rdata", c), mem_rdata, 32'h0);
      @(posedge clk); #1;
    end

    run_rows("main", tbl);
    check("sram[4]", 32'(sram_peek(4)), 32'h0000BEEF);
    check("sram[5]", 32'(sram_peek(5)), 32'h0000DEAD);
    check("sram[3FFFE]", 32'(sram_peek(32'h3FFFE)), 32'h0000F00D);
    check("sram[3FFFF]", 32'(sram_peek(32'h3FFFF)), 32'h0000CAFE);

    // Reset pulsed during the HI phase of a store to 1040 (addr 8/9).
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive(0, 1, 1040, 32'h11112222);
    end
    @(negedge clk);
    check("midrst.lo_addr", 32'(SRAM_ADDR), 32'h8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst.hi_addr", 32'(SRAM_ADDR), 32'h9);
    check("midrst.hi_we_n", 32'(SRAM_WE_N), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    check("midrst.we_n", 32'(SRAM_WE_N), 32'h1);
    check("midrst.oe", 32'(SRAM_DQ_oe), 32'h0);
    check("midrst.addr", 32'(SRAM_ADDR), 32'h0);
    check("midrst.ready", 32'(ready), 32'h1);
    check("midrst.rdata", mem_rdata, 32'h0);

    run_rows("post", post);
    check("sram[10]", 32'(sram_peek(10)), 32'h00005A5A);
    check("sram[11]", 32'(sram_peek(11)), 32'h0000A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
